// File: rtl/uart_rx_if.sv
// uart_rx_if
// Connection bundle between the UART receiver and the peripheral block
// that consumes its bytes.
//
// Signals:
//   rxd        raw serial line from the PC (idle high, asynchronous to clk)
//   rx_enable  receive enable; low blocks detection of new frames
//   rx_data    last correctly received byte
//   rx_status  level, a new byte is valid in rx_data
//   frame_err  level, the last frame was rejected
//   busy       high while a frame is being received
//
// Modports:
//   master  the receiver side: takes the line and enable, drives the results
//   slave   the consumer side: drives the line and enable, reads the results
interface uart_rx_if;
    logic       rxd;
    logic       rx_enable;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rxd,
        input  rx_enable,
        output rx_data,
        output rx_status,
        output frame_err,
        output busy
    );

    modport slave (
        output rxd,
        output rx_enable,
        input  rx_data,
        input  rx_status,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// Converts the asynchronous rxd line into bytes presented as rx_data plus a
// level-type rx_status flag that the consumer edge-detects. Stop-bit errors
// (and parity errors when parity is compiled in) raise frame_err.
//
// Parameters:
//   CLK_HZ  frequency of clk in Hz
//   BAUD    line bit rate; CLK_HZ/(BAUD*16) must be at least 2
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    uart_rx_if.master: rxd, rx_enable in; rx_data, rx_status,
//          frame_err, busy out
//
// Build option:
//   UART_RX_PARITY_EN  when defined, an even parity bit follows the data bits
module uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.master  bus
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY  = 3'd3,
`endif
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } state_t;

    state_t          state, state_n;
    logic            sync1, rxs, rxs_d;
    logic [CW-1:0]   tick_cnt;
    logic [3:0]      ph;
    logic            samp0, samp1;
    logic [7:0]      shreg, shreg_n;
    logic [3:0]      bi, bi_n;
    logic [7:0]      data_q, data_n;
    logic            status_q, status_n;
    logic            ferr_q, ferr_n;
    logic            start_edge, tick, decide, maj, perr;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_n;
`endif

    assign start_edge = (state == IDLE) && bus.rx_enable && rxs_d && !rxs;
    assign tick       = (tick_cnt == TICK_LAST);
    assign decide     = tick && (ph == 4'd9);
    // Third vote is the live sample taken on the ph=9 tick itself.
    assign maj        = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must contain an even count of ones.
    assign perr = ^{shreg, par_q};
`else
    assign perr = 1'b0;
`endif

    // Two-flop synchronizer plus an edge register; all reset to the idle level
    // so that releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= bus.rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    // Oversample tick and bit phase; both restart on the start edge so every
    // later sample point is a fixed number of clocks from that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            ph       <= 4'd0;
        end else if (start_edge) begin
            tick_cnt <= '0;
            ph       <= 4'd0;
        end else if (tick) begin
            tick_cnt <= '0;
            ph       <= ph + 4'd1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // First two majority votes, taken mid-bit at phases 7 and 8.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp0 <= 1'b1;
            samp1 <= 1'b1;
        end else if (tick) begin
            if (ph == 4'd7) samp0 <= rxs;
            if (ph == 4'd8) samp1 <= rxs;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            bi       <= 4'd0;
            data_q   <= 8'h00;
            status_q <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bi       <= bi_n;
            data_q   <= data_n;
            status_q <= status_n;
            ferr_q   <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

    // Next-state and next-output logic; every decision happens on the ph=9
    // tick of the current bit, except leaving WAIT_HI which follows the line.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bi_n     = bi;
        data_n   = data_q;
        status_n = status_q;
        ferr_n   = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_n    = par_q;
`endif
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_n = START;
                    bi_n    = 4'd0;
                end
            end
            START: begin
                if (decide) begin
                    if (maj) begin
                        state_n = IDLE;
                    end else begin
                        state_n  = DATA;
                        status_n = 1'b0;
                        ferr_n   = 1'b0;
                        bi_n     = 4'd1;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_n = {maj, shreg[7:1]};
                    bi_n    = bi + 4'd1;
                    if (bi == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    par_n   = maj;
                    bi_n    = bi + 4'd1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (decide) begin
                    if (maj && !perr) begin
                        data_n   = shreg;
                        status_n = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = maj ? IDLE : WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_status = status_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Self-checking bench for uart_rx at CLK_HZ=1_600_000, BAUD=10_000 (DIV=10,
// 160 clk per bit). Expected bytes and their expected rx_status rise cycle
// are queued when a frame is driven; a monitor queues what the receiver
// produces, and each test drains and compares the two queues.
// Build option honoured: UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int BIT_CLK = 160;
`ifdef UART_RX_PARITY_EN
    localparam int PMODE   = 1;
    localparam int DEC_OFS = 3 + 1700;
`else
    localparam int PMODE   = 0;
    localparam int DEC_OFS = 3 + 1540;
`endif

    logic clk;
    logic reset;
    uart_rx_if bus ();

    uart_rx #(
        .CLK_HZ (1_600_000),
        .BAUD   (10_000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         fall_cyc = -1;
    bit         st_prev  = 1'b0;
    bit         busy_seen = 1'b0;
    logic [7:0] exp_q[$];
    int         expt_q[$];
    logic [7:0] obs_q[$];
    int         rise_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: record each rx_status rise with its byte and cycle.
    always @(posedge clk) begin
        #1;
        if (bus.rx_status === 1'b1 && !st_prev) begin
            obs_q.push_back(bus.rx_data);
            rise_q.push_back(cyc);
        end
        if (bus.rx_status === 1'b0 && st_prev) fall_cyc = cyc;
        if (bus.busy === 1'b1) busy_seen = 1'b1;
        st_prev = (bus.rx_status === 1'b1);
    end

    // Drive one frame; par_mode 0 = none, 1 = correct even parity, 2 = wrong.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int par_mode, input bit expect_ok,
                              output int t_fall);
        @(negedge clk);
        t_fall  = cyc;
        bus.rxd = 1'b0;
        if (expect_ok) begin
            exp_q.push_back(b);
            expt_q.push_back(t_fall + DEC_OFS);
        end
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (par_mode != 0) begin
            bus.rxd = (^b) ^ (par_mode == 2);
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.rxd = stop_val;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic wait_obs(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (obs_q.size() != 0) break;
            @(negedge clk);
        end
        if (obs_q.size() != 0) got = 1'b1;
    endtask

    // Pop every queued expectation and compare against the monitor queue.
    task automatic drain(input string name);
        bit         got;
        logic [7:0] e_b, o_b;
        int         e_t, o_t;
        while (exp_q.size() != 0) begin
            wait_obs(400, got);
            e_b = exp_q.pop_front();
            e_t = expt_q.pop_front();
            total++;
            if (!got) begin
                bad++;
                $display("[TB] FAIL %s_byte: no byte received, expected %02h", name, e_b);
            end else begin
                o_b = obs_q.pop_front();
                o_t = rise_q.pop_front();
                if (o_b !== e_b) begin
                    bad++;
                    $display("[TB] FAIL %s_byte: got %02h expected %02h", name, o_b, e_b);
                end
                total++;
                if (o_t != e_t) begin
                    bad++;
                    $display("[TB] FAIL %s_rise: rx_status rose at cycle %0d expected %0d", name, o_t, e_t);
                end
            end
        end
    endtask

    task automatic test_reset();
        int viol = 0;
        reset = 1'b1;
        bus.rxd = 1'b1;
        bus.rx_enable = 1'b1;
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (bus.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %02h expected 00", bus.rx_data); end
        total++;
        if (bus.rx_status !== 1'b0) begin bad++; $display("[TB] FAIL reset_status: got %b expected 0", bus.rx_status); end
        total++;
        if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr: got %b expected 0", bus.frame_err); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b1;
        repeat (2000) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.rx_status !== 1'b0 ||
                bus.frame_err !== 1'b0 || bus.rx_data !== 8'h00) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("[TB] FAIL idle_line: %0d cycles with outputs nonzero, expected 0", viol); end
    endtask

    task automatic test_basic();
        int t;
        send_frame(8'hA5, 1'b1, PMODE, 1'b1, t);
        repeat (20) @(negedge clk);
        drain("a5");
        total++;
        if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL a5_ferr: got %b expected 0", bus.frame_err); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL a5_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        send_frame(8'h3C, 1'b1, PMODE, 1'b1, t1);
        send_frame(8'hC3, 1'b1, PMODE, 1'b1, t2);
        repeat (20) @(negedge clk);
        drain("b2b");
        total++;
        if (fall_cyc != t2 + 103) begin
            bad++;
            $display("[TB] FAIL b2b_fall: rx_status fell at cycle %0d expected %0d", fall_cyc, t2 + 103);
        end
    endtask

    task automatic test_glitch();
        busy_seen = 1'b0;
        @(negedge clk);
        bus.rxd = 1'b0;
        repeat (40) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (busy_seen !== 1'b1) begin bad++; $display("[TB] FAIL glitch_seen: busy never rose, got %b expected 1", busy_seen); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy: got %b expected 0", bus.busy); end
        total++;
        if (bus.rx_status !== 1'b1) begin bad++; $display("[TB] FAIL glitch_status: got %b expected 1", bus.rx_status); end
        total++;
        if (bus.rx_data !== 8'hC3) begin bad++; $display("[TB] FAIL glitch_data: got %02h expected c3", bus.rx_data); end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL glitch_out: %0d spurious bytes, expected 0", obs_q.size()); end
    endtask

    task automatic test_stop_error();
        int t;
        send_frame(8'h55, 1'b0, PMODE, 1'b0, t);
        repeat (200) @(negedge clk);
        total++;
        if (bus.frame_err !== 1'b1) begin bad++; $display("[TB] FAIL stop_ferr: got %b expected 1", bus.frame_err); end
        total++;
        if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL stop_hold: busy got %b expected 1", bus.busy); end
        total++;
        if (bus.rx_data !== 8'hC3) begin bad++; $display("[TB] FAIL stop_data: got %02h expected c3", bus.rx_data); end
        total++;
        if (bus.rx_status !== 1'b0) begin bad++; $display("[TB] FAIL stop_status: got %b expected 0", bus.rx_status); end
        bus.rxd = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL stop_release: busy got %b expected 0", bus.busy); end
        send_frame(8'h12, 1'b1, PMODE, 1'b1, t);
        repeat (20) @(negedge clk);
        drain("recover");
        total++;
        if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL recover_ferr: got %b expected 0", bus.frame_err); end
    endtask

    task automatic test_enable();
        int t;
        bus.rx_enable = 1'b0;
        busy_seen = 1'b0;
        send_frame(8'hFF, 1'b1, PMODE, 1'b0, t);
        repeat (50) @(negedge clk);
        total++;
        if (busy_seen !== 1'b0) begin bad++; $display("[TB] FAIL dis_busy: busy rose, got %b expected 0", busy_seen); end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL dis_out: %0d bytes, expected 0", obs_q.size()); end
        total++;
        if (bus.rx_data !== 8'h12) begin bad++; $display("[TB] FAIL dis_data: got %02h expected 12", bus.rx_data); end
        bus.rx_enable = 1'b1;
        repeat (50) @(negedge clk);
        fork
            send_frame(8'h81, 1'b1, PMODE, 1'b1, t);
            begin
                repeat (400) @(negedge clk);
                bus.rx_enable = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        drain("midoff");
        bus.rx_enable = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int t;
        send_frame(8'h07, 1'b1, 1, 1'b1, t);
        repeat (20) @(negedge clk);
        drain("par_ok");
        send_frame(8'h07, 1'b1, 2, 1'b0, t);
        repeat (20) @(negedge clk);
        total++;
        if (bus.frame_err !== 1'b1) begin bad++; $display("[TB] FAIL par_ferr: got %b expected 1", bus.frame_err); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL par_busy: got %b expected 0", bus.busy); end
        total++;
        if (bus.rx_status !== 1'b0) begin bad++; $display("[TB] FAIL par_status: got %b expected 0", bus.rx_status); end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL par_out: %0d bytes, expected 0", obs_q.size()); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int t;
        fork
            send_frame(8'h5A, 1'b1, PMODE, 1'b0, t);
            begin
                repeat (500) @(negedge clk);
                reset = 1'b0;
                #1;
                total++;
                if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", bus.busy); end
                total++;
                if (bus.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_data: got %02h expected 00", bus.rx_data); end
            end
        join
        reset = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (obs_q.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_after: bytes=%0d busy=%b expected 0/0", obs_q.size(), bus.busy);
        end
    endtask

    initial begin
        $display("[TB] uart_rx bench start");
        test_reset();
        test_basic();
        repeat (100) @(negedge clk);
        test_back_to_back();
        repeat (100) @(negedge clk);
        test_glitch();
        test_stop_error();
        repeat (100) @(negedge clk);
        test_enable();
        repeat (100) @(negedge clk);
`ifdef UART_RX_PARITY_EN
        test_parity();
        repeat (100) @(negedge clk);
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART serial receiver feeding the memory-mapped peripheral block: it converts the asynchronous `rxd` line from the PC into 8-bit bytes and presents them as `rx_data` and `rx_status`, which the peripheral edge-detects and latches into its RX flag. The receiver frames 8N1 traffic using 16x oversampling and majority-vote bit sampling. It reports stop-bit errors, and parity errors when parity is compiled in.

## Interface
- `CLK_HZ`, 100_000_000, frequency of `clk` in Hz.
- `BAUD`, 9600, line bit rate.
- `DIV` (localparam), CLK_HZ/(BAUD*16) truncated, clk cycles per oversample tick; must be ≥ 2.
- `clk`  in  1  system clock; reset is asynchronous, active-low, named `reset`, clock `clk`.
- `reset`  in  1  asynchronous active-low reset.
- `rxd`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `rx_enable`  in  1  receive enable; when low, no new frame is started.
- `rx_data`  out  8  last correctly received byte.
- `rx_status`  out  1  level: a new byte is valid in `rx_data`.
- `frame_err`  out  1  level: the last frame was rejected.
- `busy`  out  1  high while a frame is being received (state ≠ IDLE).

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rxs`.
- Tick generator: a counter 0..DIV-1 that emits a 1-clk `tick` at DIV-1. It is forced to 0 on the start-edge cycle so that ticks are phase-locked to the edge.
- Bit phase counter `ph` (4 bit, 0..15) advances on each tick and wraps. Bit index `bi` counts 0 = start, 1..8 = data (LSB first), then [parity], then stop.
- Sampling: `rxs` is captured at ph = 7, 8 and 9. The bit value is the majority of the three samples, decided at the tick where ph = 9.
- State machine:
  - **IDLE**: a falling edge of `rxs` with `rx_enable`=1 → START; `ph` and the tick counter are cleared.
  - **START**: majority = 1 is a false start → IDLE, no output change. Majority = 0 → DATA, `rx_status` cleared, `frame_err` cleared.
  - **DATA**: shift the bit into the shift register at each decision. After the 8th bit → PARITY if compiled in, else STOP.
  - **PARITY**: store the parity bit → STOP.
  - **STOP**: majority = 1 and no parity error → `rx_data` ← shift register, `rx_status` ← 1, → IDLE. Otherwise → `frame_err` ← 1, `rx_data` unchanged, → WAIT_HI.
  - **WAIT_HI**: remain until `rxs`=1 (break or line-low condition), then → IDLE.
- `rx_enable` falling mid-frame does not abort the frame; it only blocks new start detection in IDLE.
- `rx_status` remains high until the next validated start bit. The consumer must edge-detect it, because the consumer's clock may be slower than `clk`.
- Reset values: `rx_data`=8'h00, `rx_status`=0, `frame_err`=0, `busy`=0, state IDLE, all counters 0. Reset asserted mid-frame discards the frame immediately.

## Timing
- Start detection happens 2–3 clk after the `rxd` fall (synchronizer plus edge register).
- Let E be the clk cycle in which the start edge is detected in IDLE:
  - start decision at E + 10·DIV;
  - data bit k (1..8) decided at E + (16k+10)·DIV;
  - stop decision at E + (16·9+10)·DIV, or E + (16·10+10)·DIV with parity.
- `rx_status`, `rx_data` and `frame_err` update on the clk edge of the stop decision.
- `busy` rises at E+1 and falls on the cycle the FSM re-enters IDLE.
- Back-to-back frames: a start edge arriving 6 ticks after the stop decision is accepted.
- A new byte overwrites `rx_data` with no overrun flag; the consumer must read within one frame time.

## Configuration
- `UART_RX_PARITY_EN` defined: an even parity bit follows the data bits. A mismatch is treated as a frame error: `frame_err`=1, no `rx_data` update, the FSM goes to WAIT_HI, or to IDLE if the stop bit = 1.
- Undefined: no PARITY state; the frame is 10 bits (8N1).

## Test plan
Bench uses CLK_HZ=1_600_000 and BAUD=10_000, giving DIV=10 and a bit time of 160 clk.
- Reset then idle line: all outputs 0, `busy`=0 for 2000 clk.
- Send 8'hA5 (8N1): `rx_data`=8'hA5 and `rx_status` rises exactly at E+1540 clk; `frame_err`=0; `busy` low afterwards.
- Send 8'h3C immediately followed by 8'hC3: `rx_status` falls at the second start validation (E2+100) and rises again with `rx_data`=8'hC3.
- Glitch: `rxd` low for 40 clk (4 ticks) → false start, back to IDLE; `rx_status` and `rx_data` unchanged.
- Stop bit forced 0 while sending 8'h55: `frame_err`=1, `rx_data` keeps its previous value, `busy` held until `rxd` returns high; then 8'h12 is received cleanly and `frame_err` clears.
- `rx_enable`=0 while sending 8'hFF: no reception, `busy`=0. Deassert `rx_enable` mid-frame of 8'h81: the byte still completes with `rx_data`=8'h81.
- With `UART_RX_PARITY_EN`: 8'h07 with parity 1 → accepted; with parity 0 → `frame_err`=1.
